// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - 4-entry first-word-fall-through FIFO controller driving an external register array
module fifo_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mem_write_data,
  output logic [1:0]       mem_write_addr,
  output logic             mem_write_en,
  output logic [1:0]       mem_read_addr,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic [2:0]       count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam logic [2:0] DEPTH = 3'd4;

  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count_q;
  logic       overflow_q;
  logic       push;
  logic       pop;

  // Status flags come only from the registered count, so in_ready never
  // depends combinationally on out_ready; a pop cannot open a slot for a
  // same-cycle push into a full queue.
  always_comb begin
    full           = (count_q == DEPTH);
    empty          = (count_q == 3'd0);
    in_ready       = !full && !rst;
    out_valid      = !empty;
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    mem_write_en   = push;
    mem_write_addr = wr_ptr;
    mem_write_data = in_data;
    mem_read_addr  = rd_ptr;
    out_data       = mem_read_data;
    count          = count_q;
    overflow       = overflow_q;
  end

  // Pointer, occupancy and sticky overflow state; array contents are left
  // untouched by reset because empty hides any stale word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (pop && !push) count_q <= count_q - 3'd1;
      if (in_valid && full) overflow_q <= 1'b1;
    end
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH fixed at 4 entries; 2-bit pointers drive the 4-word register array's address ports.
REQ-003 Reset is synchronous, active-high; single clock.
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  producer has a word on in_data.
REQ-007 in_data  input  WIDTH  producer word.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 out_valid  output  1  out_data holds the oldest stored word.
REQ-010 out_data  output  WIDTH  oldest stored word.
REQ-011 out_ready  input  1  consumer takes out_data this cycle.
REQ-012 mem_write_data  output  WIDTH  to array write_data.
REQ-013 mem_write_addr  output  2  to array write_addr.
REQ-014 mem_write_en  output  1  to array write_en.
REQ-015 mem_read_addr  output  2  to array read_addr.
REQ-016 mem_read_data  input  WIDTH  from array read_data (combinational read).
REQ-017 count  output  3  stored words, 0..4.
REQ-018 full  output  1  count == 4.
REQ-019 empty  output  1  count == 0.
REQ-020 overflow  output  1  sticky: push attempted while full.

Function
REQ-021 push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-022 in_ready = !full & !rst; no write-through when full, even with a same-cycle pop.
REQ-023 out_valid = !empty; out_data = mem_read_data; mem_read_addr = rd_ptr (first-word fall-through).
REQ-024 mem_write_en = push; mem_write_addr = wr_ptr; mem_write_data = in_data; all combinational.
REQ-025 On push: wr_ptr <= wr_ptr+1, mod 4 (3 wraps to 0).
REQ-026 On pop: rd_ptr <= rd_ptr+1, mod 4.
REQ-027 count: +1 push only, -1 pop only, unchanged on both or neither; never exceeds 4, never below 0.
REQ-028 Simultaneous push and pop at count 1..3: both pointers advance, count holds.
REQ-029 Empty: pop impossible (out_valid=0); out_data don't-care.
REQ-030 Write latency: word pushed at edge N is presented on out_data/out_valid from cycle N+1.
REQ-031 Order: words leave in exactly push order, across pointer wrap.
REQ-032 overflow sets on any cycle with in_valid=1 and full=1; cleared only by rst.
REQ-033 full, empty derived from registered count; no combinational path from out_ready to in_ready.

Reset
REQ-034 While rst=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0.
REQ-035 While rst=1: mem_write_en=0, in_ready=0; after reset: out_valid=0, empty=1, full=0.
REQ-036 Array contents not cleared by reset; stale words never presented because empty=1.
REQ-037 rst mid-operation discards all stored words; first push after reset writes address 0.

Verification
REQ-038 Reset, push 0x11,0x22,0x33,0x44 (out_ready=0) -> count=4, full=1, in_ready=0, mem_write_addr 0,1,2,3.
REQ-039 From full, in_valid=1 with 0x55 -> no mem_write_en, overflow=1, count stays 4; pop 4 -> 0x11,0x22,0x33,0x44 then empty=1, overflow still 1.
REQ-040 Push 0xA5 into empty -> out_valid=0 same cycle, out_valid=1 and out_data=0xA5 next cycle.
REQ-041 Count=2, push and pop same cycle for 6 cycles -> count stays 2, pointers wrap past 3, output order matches input.
REQ-042 Count=3, assert rst one cycle with in_valid=1 -> mem_write_en=0; next cycle count=0, empty=1, overflow=0, wr_ptr=0.
REQ-043 Random valid/ready, 1000 cycles -> scoreboard match, count never >4, no push while full, no pop while empty.
